// File: rtl/afe_spi_pkg.sv
// Shared definitions for the AFE4490 SPI master: FSM encoding, default frame
// geometry and the AFE4490 register address map.
package afe_spi_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [7:0] CONTROL0      = 8'h00;
    localparam logic [7:0] LED2STC       = 8'h01;
    localparam logic [7:0] LED2ENDC      = 8'h02;
    localparam logic [7:0] LED2LEDSTC    = 8'h03;
    localparam logic [7:0] LED2LEDENDC   = 8'h04;
    localparam logic [7:0] ALED2STC      = 8'h05;
    localparam logic [7:0] ALED2ENDC     = 8'h06;
    localparam logic [7:0] LED1STC       = 8'h07;
    localparam logic [7:0] LED1ENDC      = 8'h08;
    localparam logic [7:0] LED1LEDSTC    = 8'h09;
    localparam logic [7:0] LED1LEDENDC   = 8'h0A;
    localparam logic [7:0] ALED1STC      = 8'h0B;
    localparam logic [7:0] ALED1ENDC     = 8'h0C;
    localparam logic [7:0] LED2CONVST    = 8'h0D;
    localparam logic [7:0] LED2CONVEND   = 8'h0E;
    localparam logic [7:0] ALED2CONVST   = 8'h0F;
    localparam logic [7:0] ALED2CONVEND  = 8'h10;
    localparam logic [7:0] LED1CONVST    = 8'h11;
    localparam logic [7:0] LED1CONVEND   = 8'h12;
    localparam logic [7:0] ALED1CONVST   = 8'h13;
    localparam logic [7:0] ALED1CONVEND  = 8'h14;
    localparam logic [7:0] ADCRSTSTCT0   = 8'h15;
    localparam logic [7:0] ADCRSTENDCT0  = 8'h16;
    localparam logic [7:0] ADCRSTSTCT1   = 8'h17;
    localparam logic [7:0] ADCRSTENDCT1  = 8'h18;
    localparam logic [7:0] ADCRSTSTCT2   = 8'h19;
    localparam logic [7:0] ADCRSTENDCT2  = 8'h1A;
    localparam logic [7:0] ADCRSTSTCT3   = 8'h1B;
    localparam logic [7:0] ADCRSTENDCT3  = 8'h1C;
    localparam logic [7:0] PRPCOUNT      = 8'h1D;
    localparam logic [7:0] CONTROL1      = 8'h1E;
    localparam logic [7:0] SPARE1        = 8'h1F;
    localparam logic [7:0] TIAGAIN       = 8'h20;
    localparam logic [7:0] TIA_AMB_GAIN  = 8'h21;
    localparam logic [7:0] LEDCNTRL      = 8'h22;
    localparam logic [7:0] CONTROL2      = 8'h23;
    localparam logic [7:0] SPARE2        = 8'h24;
    localparam logic [7:0] SPARE3        = 8'h25;
    localparam logic [7:0] SPARE4        = 8'h26;
    localparam logic [7:0] RESERVED1     = 8'h27;
    localparam logic [7:0] RESERVED2     = 8'h28;
    localparam logic [7:0] ALARM         = 8'h29;
    localparam logic [7:0] LED2VAL       = 8'h2A;
    localparam logic [7:0] ALED2VAL      = 8'h2B;
    localparam logic [7:0] LED1VAL       = 8'h2C;
    localparam logic [7:0] ALED1VAL      = 8'h2D;
    localparam logic [7:0] LED2_ALED2VAL = 8'h2E;
    localparam logic [7:0] LED1_ALED1VAL = 8'h2F;
    localparam logic [7:0] DIAG          = 8'h30;

endpackage

// File: rtl/spi_edge_gen.sv
// SCLK half-period timer: while enabled, flags the i_clk cycle that precedes
// each leading/trailing SCLK edge and reports when the current bit is the last.
module spi_edge_gen #(
    parameter int CLK_DIV = 4,
    parameter int N       = 32
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic lead_stb,
    output logic trail_stb,
    output logic last_bit
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(N + 1);

    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          phase_q, phase_d;
    logic          half_end;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        phase_d    = phase_q;
        half_end   = i_en && (half_cnt_q == HW'(CLK_DIV - 1));
        lead_stb   = half_end && !phase_q;
        trail_stb  = half_end && phase_q;
        last_bit   = (bit_cnt_q == BW'(N - 1));

        if (!i_en) begin
            half_cnt_d = '0;
            bit_cnt_d  = '0;
            phase_d    = 1'b0;
        end else if (half_end) begin
            half_cnt_d = '0;
            phase_d    = !phase_q;
            if (phase_q) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else begin
            half_cnt_d = half_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            phase_q    <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
        end
    end

endmodule

// File: rtl/afe_spi_master.sv
// SPI master for the AFE4490: one address+data frame per request, configurable
// SCLK mode and CS setup/hold, with all SPI pins driven straight from flops.
module afe_spi_master
    import afe_spi_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CLK_DIV  = 4,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_dv,
    input  logic              i_rd_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_ready,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_cs_n,
    input  logic              i_miso
);

    localparam int   N         = ADDR_W + DATA_W;
    localparam int   CNT_MAX   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int   CW        = $clog2(CNT_MAX + 1);
    localparam logic SCLK_IDLE = 1'(CPOL);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      sr_q, sr_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_q, rd_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic              shift_en, lead_stb, trail_stb, last_bit;
    logic              shift_stb, sample_stb;
    logic [N-1:0]      frame;

    assign shift_en = (state_q == ST_SHIFT);

    spi_edge_gen #(
        .CLK_DIV (CLK_DIV),
        .N       (N)
    ) u_edge_gen (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (shift_en),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .last_bit  (last_bit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        rd_d      = rd_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        done_d    = 1'b0;

        frame = {i_addr, (i_rd_wr ? {DATA_W{1'b0}} : i_wr_data)};
        // Mode 0 pre-drives bit N-1 at accept, so only the N-1 later bits move on trailing edges.
        shift_stb  = (CPHA == 0) ? (trail_stb && !last_bit) : lead_stb;
        sample_stb = (CPHA == 0) ? lead_stb : trail_stb;

        unique case (state_q)
            ST_IDLE: begin
                if (i_dv && ready_q) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    rd_d    = i_rd_wr;
                    if (CPHA == 0) begin
                        mosi_d = frame[N-1];
                        sr_d   = frame << 1;
                    end else begin
                        mosi_d = 1'b0;
                        sr_d   = frame;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (lead_stb || trail_stb) begin
                    sclk_d = !sclk_q;
                end
                if (shift_stb) begin
                    mosi_d = sr_q[N-1];
                    sr_d   = sr_q << 1;
                end
                if (sample_stb) begin
                    rx_d = {rx_q[DATA_W-2:0], i_miso};
                end
                if (trail_stb && last_bit) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rd_q) begin
                        rd_data_d = rx_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // NOTE: the datapath registers are reset along with the control flops, so a frame
    // aborted by reset leaves no stale shift or capture bits behind.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            rx_q      <= '0;
            rd_data_q <= '0;
            rd_q      <= 1'b0;
            sclk_q    <= SCLK_IDLE;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            rx_q      <= rx_d;
            rd_data_q <= rd_data_d;
            rd_q      <= rd_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_done    = done_q;
    assign o_rd_data = rd_data_q;
    assign o_sclk    = sclk_q;
    assign o_mosi    = mosi_q;
    assign o_cs_n    = cs_n_q;

endmodule

// File: tb/tb_afe_spi_master.sv
// Bench for afe_spi_master: a mode-0 /4 instance and a mode-3 /1 instance, each
// talking to a bit-level SPI slave model, checked against frame-level expectations.
module tb_afe_spi_master;

    localparam int AW    = 8;
    localparam int DW    = 24;
    localparam int N     = AW + DW;
    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]         dv;
    logic [1:0]         rd_wr;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wr_data;
    wire  [1:0]         ready, done, sclk, mosi, cs_n;
    wire  [1:0][DW-1:0] rd_data;
    logic               miso_a = 1'b0;
    logic               miso_b = 1'b0;

    // Frame-level reference: what the slave must see and what o_rd_data must hold.
    logic [1:0][N-1:0]  tx;
    logic [1:0][N-1:0]  exp_cap;
    logic [1:0][DW-1:0] exp_rd;
    logic [1:0][DW-1:0] pend_resp;
    logic [1:0]         pend_rd;
    int                 lat [2];

    logic [N-1:0] cap_a, cap_b;
    int           cnt_a, cnt_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    afe_spi_master #(
        .ADDR_W(AW), .DATA_W(DW), .CLK_DIV(DIV_A), .CPOL(0), .CPHA(0),
        .CS_SETUP(2), .CS_HOLD(2)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_dv(dv[0]), .i_rd_wr(rd_wr[0]),
        .i_addr(addr[0]), .i_wr_data(wr_data[0]), .o_ready(ready[0]),
        .o_done(done[0]), .o_rd_data(rd_data[0]), .o_sclk(sclk[0]),
        .o_mosi(mosi[0]), .o_cs_n(cs_n[0]), .i_miso(miso_a)
    );

    afe_spi_master #(
        .ADDR_W(AW), .DATA_W(DW), .CLK_DIV(DIV_B), .CPOL(1), .CPHA(1),
        .CS_SETUP(2), .CS_HOLD(2)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_dv(dv[1]), .i_rd_wr(rd_wr[1]),
        .i_addr(addr[1]), .i_wr_data(wr_data[1]), .o_ready(ready[1]),
        .o_done(done[1]), .o_rd_data(rd_data[1]), .o_sclk(sclk[1]),
        .o_mosi(mosi[1]), .o_cs_n(cs_n[1]), .i_miso(miso_b)
    );

    // Mode-0 slave: first bit out at CS fall, samples on rising SCLK, shifts on falling.
    always @(negedge cs_n[0]) begin
        cnt_a  = 0;
        cap_a  = '0;
        miso_a = tx[0][N-1];
    end
    always @(posedge sclk[0]) if (cs_n[0] === 1'b0) begin
        cap_a = {cap_a[N-2:0], mosi[0]};
        cnt_a++;
    end
    always @(negedge sclk[0]) if (cs_n[0] === 1'b0 && cnt_a < N) miso_a = tx[0][N-1-cnt_a];

    // Mode-3 slave: drives on falling (leading) SCLK, samples on rising (trailing).
    always @(negedge cs_n[1]) begin
        cnt_b = 0;
        cap_b = '0;
    end
    always @(negedge sclk[1]) if (cs_n[1] === 1'b0 && cnt_b < N) miso_b = tx[1][N-1-cnt_b];
    always @(posedge sclk[1]) if (cs_n[1] === 1'b0) begin
        cap_b = {cap_b[N-2:0], mosi[1]};
        cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling clock edge of the first cycle after the accepting edge.
    task automatic start_frame(input int i, input logic rd, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] resp);
        int k = 0;
        while (ready[i] !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("ready before request", 32'(ready[i]), 32'd1);
        dv[i]        = 1'b1;
        rd_wr[i]     = rd;
        addr[i]      = a;
        wr_data[i]   = d;
        tx[i]        = {AW'($urandom), resp};
        exp_cap[i]   = {a, (rd ? {DW{1'b0}} : d)};
        pend_rd[i]   = rd;
        pend_resp[i] = resp;
        @(posedge clk);
        @(negedge clk);
        dv[i]      = 1'b0;
        rd_wr[i]   = 1'($urandom);
        addr[i]    = AW'($urandom);
        wr_data[i] = DW'($urandom);
    endtask

    // n0 is the cycle number (accept cycle = 0) at which this is called.
    task automatic finish_frame(input int i, input int n0, input string tag);
        int   n    = n0;
        logic seen = 1'b0;
        logic held = 1'b1;
        while (!seen && n < 1000) begin
            if (done[i] === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (rd_data[i] !== exp_rd[i]) held = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        check({tag, " done latency"}, 32'(n), 32'(lat[i]));
        check({tag, " rd_data held in frame"}, 32'(held), 32'd1);
        if (pend_rd[i]) exp_rd[i] = pend_resp[i];
        check({tag, " rd_data"}, 32'(rd_data[i]), 32'(exp_rd[i]));
        check({tag, " slave capture"}, (i == 0) ? cap_a : cap_b, exp_cap[i]);
        check({tag, " slave bit count"}, 32'((i == 0) ? cnt_a : cnt_b), 32'(N));
        check({tag, " cs_n high at done"}, 32'(cs_n[i]), 32'd1);
        check({tag, " sclk idle level"}, 32'(sclk[i]), 32'(i));
    endtask

    task automatic after_done(input int i, input string tag);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(done[i]), 32'd0);
        check({tag, " ready in idle"}, 32'(ready[i]), 32'd1);
    endtask

    task automatic run_frame(input int i, input logic rd, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] resp, input string tag);
        start_frame(i, rd, a, d, resp);
        finish_frame(i, 1, tag);
        after_done(i, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        logic seen;
        logic stayed;

        lat[0]  = 261;
        lat[1]  = 69;
        dv      = '0;
        rd_wr   = '0;
        addr    = '0;
        wr_data = '0;
        tx      = '0;
        exp_rd  = '0;
        pend_rd = '0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset ready", 32'(ready[i]), 32'd1);
            check("reset done", 32'(done[i]), 32'd0);
            check("reset cs_n", 32'(cs_n[i]), 32'd1);
            check("reset sclk", 32'(sclk[i]), 32'(i));
            check("reset mosi", 32'(mosi[i]), 32'd0);
            check("reset rd_data", 32'(rd_data[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(0, 1'b0, 8'h01, 24'h0017C0, 24'h000000, "write 0x01");
        run_frame(0, 1'b1, 8'h2A, 24'h000000, 24'hABCDEF, "read 0x2A");
        run_frame(1, 1'b1, 8'h2C, 24'h000000, 24'h123456, "mode3 read");

        for (int r = 0; r < 3; r++) begin
            run_frame(0, 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), "rand mode0");
            run_frame(1, 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom), "rand mode3");
        end

        // A request raised mid-frame must be dropped, not queued.
        start_frame(0, 1'b0, 8'h05, 24'h5A5A5A, 24'h000000);
        repeat (40) @(negedge clk);
        dv[0]      = 1'b1;
        rd_wr[0]   = 1'b1;
        addr[0]    = 8'hFF;
        wr_data[0] = 24'hFFFFFF;
        check("ready low mid-frame", 32'(ready[0]), 32'd0);
        repeat (5) @(negedge clk);
        dv[0] = 1'b0;
        finish_frame(0, 46, "ignored dv");
        after_done(0, "ignored dv");
        stayed = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (cs_n[0] !== 1'b1) stayed = 1'b0;
        end
        check("no queued frame", 32'(stayed), 32'd1);

        // Back-to-back: next request raised in the done cycle.
        start_frame(0, 1'b1, 8'h2B, 24'h000000, DW'($urandom));
        finish_frame(0, 1, "b2b first");
        start_frame(0, 1'b0, 8'h22, DW'($urandom), 24'h000000);
        check("b2b cs_n low after 1-cycle gap", 32'(cs_n[0]), 32'd0);
        finish_frame(0, 1, "b2b second");
        after_done(0, "b2b second");

        // Reset pulse at bit 10 aborts the frame.
        start_frame(0, 1'b0, 8'h10, DW'($urandom), 24'h000000);
        k = 0;
        while (cnt_a < 10 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("reached bit 10", 32'(cnt_a >= 10), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort cs_n", 32'(cs_n[0]), 32'd1);
        check("abort sclk", 32'(sclk[0]), 32'd0);
        exp_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (done[0] !== 1'b0) seen = 1'b1;
        end
        check("no done after abort", 32'(seen), 32'd0);
        run_frame(0, 1'b0, 8'h00, 24'h000001, 24'h000000, "post-reset write");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
